key_input_scheduler: RTL and testbench

//  Shares the single keyConverter (key[7:0] -> code[3:0], registered on clk) between two
//  key sources: the UART keyboard receiver and the on-board pushbutton encoder.

---
 rtl/key_sched_pkg.sv | 25 ++
 rtl/key_fifo.sv | 52 +++++
 rtl/key_input_scheduler.sv | 133 +++++++++++++
 tb/tb_key_input_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key input scheduler: FSM states, the
// ingress source identifiers and the converter's "no action" code.
package key_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    typedef enum logic {
        SRC_UART = 1'b0,
        SRC_BTN  = 1'b1
    } src_t;

    localparam logic [3:0] NO_ACTION_CODE = 4'h0;

    // Saturating add used for the drop counter (at most 2 drops per cycle).
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous key-byte queue: up to two writes and one pop per cycle.
// The caller guarantees it never writes more bytes than there are free slots.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    wr_count,
    input  logic [7:0]    wr_data0,
    input  logic [7:0]    wr_data1,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] free_slots
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_inc;
    logic [CW-1:0] count;

    assign wr_ptr_inc = wr_ptr + 1'b1;
    assign head       = mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign free_slots = CW'(DEPTH) - count;

    // NOTE: storage is left unreset; only pointers and occupancy decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_count != 2'd0) mem[wr_ptr]     <= wr_data0;
        if (wr_count == 2'd2) mem[wr_ptr_inc] <= wr_data1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= wr_ptr + AW'(wr_count);
            count  <= count + CW'(wr_count) - CW'(pop);
        end
    end

endmodule

// File: rtl/key_input_scheduler.sv
// Arbitrates UART and pushbutton key bytes into a shared queue, feeds them one at a
// time through the external key converter and offers each action code on valid/ready.
module key_input_scheduler
    import key_sched_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] IDLE_KEY    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_valid,
    input  logic [7:0] uart_key,
    input  logic       btn_valid,
    input  logic [7:0] btn_key,
    output logic [7:0] conv_key,
    input  logic [3:0] conv_code,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    input  logic       cmd_ready,
    output logic       fifo_full,
    output logic [7:0] drop_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t        state;
    state_t        state_nxt;
    src_t          rr_pri;
    logic [HW-1:0] hold_cnt;
    logic          hold_done;

    logic [7:0]    head;
    logic          empty;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] avail;
    logic          pop;

    logic [1:0]    wr_count;
    logic [1:0]    drops;
    logic [7:0]    wr_data0;
    logic [7:0]    wr_data1;

    key_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_count   (wr_count),
        .wr_data0   (wr_data0),
        .wr_data1   (wr_data1),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (fifo_full),
        .free_slots (free_slots)
    );

    assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign pop       = !empty && ((state == ST_IDLE) || (state == ST_OFFER && cmd_ready));
    // A same-cycle pop frees its slot for this cycle's ingress.
    assign avail     = free_slots + CW'(pop);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_count = 2'd0;
        drops    = 2'd0;
        wr_data0 = uart_key;
        wr_data1 = btn_key;
        if (uart_valid && btn_valid) begin
            if (rr_pri == SRC_BTN) begin
                wr_data0 = btn_key;
                wr_data1 = uart_key;
            end
            if (avail >= CW'(2)) begin
                wr_count = 2'd2;
            end else if (avail == CW'(1)) begin
                wr_count = 2'd1;
                drops    = 2'd1;
            end else begin
                drops    = 2'd2;
            end
        end else if (uart_valid || btn_valid) begin
            wr_data0 = uart_valid ? uart_key : btn_key;
            if (avail != '0) wr_count = 2'd1;
            else             drops    = 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_DRIVE;
            ST_DRIVE: if (hold_done)
                          state_nxt = (conv_code == NO_ACTION_CODE) ? ST_IDLE : ST_OFFER;
            ST_OFFER: if (cmd_ready) state_nxt = empty ? ST_IDLE : ST_DRIVE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_pri     <= SRC_UART;
            hold_cnt   <= '0;
            conv_key   <= IDLE_KEY;
            cmd_valid  <= 1'b0;
            cmd_code   <= 4'h0;
            drop_count <= 8'h00;
        end else begin
            state      <= state_nxt;
            drop_count <= sat_add8(drop_count, drops);
            if (uart_valid && btn_valid)
                rr_pri <= (rr_pri == SRC_UART) ? SRC_BTN : SRC_UART;

            if (pop) begin
                conv_key <= head;
                hold_cnt <= '0;
            end else if (state == ST_DRIVE) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_done) begin
                    conv_key <= IDLE_KEY;
                    if (conv_code != NO_ACTION_CODE) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= conv_code;
                    end
                end
            end

            if (state == ST_OFFER && cmd_ready) cmd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_input_scheduler.sv
// Directed and random checks of key_input_scheduler against a queue-based reference
// model; the key converter is modelled as a registered conv_key[3:0].
module tb_key_input_scheduler;

    localparam int         DEPTH = 4;
    localparam int         HOLD  = 2;
    localparam logic [7:0] IDLE  = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_key = 8'h00;
    logic       btn_valid = 1'b0;
    logic [7:0] btn_key = 8'h00;
    logic [7:0] conv_key;
    logic [3:0] conv_code;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready = 1'b0;
    logic       fifo_full;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_left;
    bit         m_offering;
    logic [3:0] m_code;
    logic [7:0] m_key;
    int         m_drops;
    bit         m_rr_btn;
    int         cyc;
    int         hs_cycle[$];
    logic [3:0] hs_code[$];

    key_input_scheduler #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .IDLE_KEY(IDLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_valid (uart_valid),
        .uart_key   (uart_key),
        .btn_valid  (btn_valid),
        .btn_key    (btn_key),
        .conv_key   (conv_key),
        .conv_code  (conv_code),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conv_code <= 4'h0;
        else        conv_code <= conv_key[3:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_left     = 0;
        m_offering = 0;
        m_code     = 4'h0;
        m_key      = 8'h00;
        m_drops    = 0;
        m_rr_btn   = 0;
    endtask

    task automatic model_push(input logic [7:0] k);
        if (q.size() < DEPTH) q.push_back(k);
        else if (m_drops < 255) m_drops++;
    endtask

    // One clock edge of the reference: a key occupies the converter for HOLD cycles,
    // then its low nibble (if non-zero) is offered until accepted.
    task automatic model_edge(input bit uv, input logic [7:0] uk, input bit bv,
                              input logic [7:0] bk, input bit rdy);
        bit take;
        take = 0;
        if (m_left == 0 && !m_offering) take = (q.size() > 0);
        else if (m_offering && rdy)     take = (q.size() > 0);

        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_key[3:0] != 4'h0) begin
                m_offering = 1;
                m_code     = m_key[3:0];
            end
        end else if (m_offering && rdy) begin
            m_offering = 0;
        end

        if (take) begin
            m_key      = q.pop_front();
            m_left     = HOLD;
            m_offering = 0;
        end

        if (uv && bv) begin
            if (m_rr_btn) begin model_push(bk); model_push(uk); end
            else          begin model_push(uk); model_push(bk); end
            m_rr_btn = !m_rr_btn;
        end else if (uv) begin
            model_push(uk);
        end else if (bv) begin
            model_push(bk);
        end
    endtask

    task automatic check_outputs();
        check("cmd_valid",  cmd_valid,  m_offering);
        check("cmd_code",   cmd_code,   m_code);
        check("conv_key",   conv_key,   (m_left > 0) ? m_key : IDLE);
        check("fifo_full",  fifo_full,  q.size() == DEPTH);
        check("drop_count", drop_count, m_drops);
    endtask

    // Called at edge+1: drive inputs, record any handshake, clock once, check at edge+1.
    task automatic step(input bit uv, input logic [7:0] uk, input bit bv,
                        input logic [7:0] bk, input bit rdy);
        uart_valid = uv;
        uart_key   = uk;
        btn_valid  = bv;
        btn_key    = bk;
        cmd_ready  = rdy;
        #1;
        if (cmd_valid && cmd_ready) begin
            hs_cycle.push_back(cyc);
            hs_code.push_back(cmd_code);
        end
        @(posedge clk);
        model_edge(uv, uk, bv, bk, rdy);
        cyc++;
        #1;
        uart_valid = 1'b0;
        btn_valid  = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, rdy);
    endtask

    initial begin
        int base;
        model_reset();
        cyc = 0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // 1: single key latency and hold while not ready
        cyc = 0;
        step(1, 8'h05, 0, 8'h00, 0);
        step(0, 8'h00, 0, 8'h00, 0);
        check("t1_conv_key_c2", conv_key, 8'h05);
        step(0, 8'h00, 0, 8'h00, 0);
        check("t1_conv_key_c3", conv_key, 8'h05);
        step(0, 8'h00, 0, 8'h00, 0);
        check("t1_valid_c4", cmd_valid, 1'b1);
        check("t1_code_c4", cmd_code, 4'h5);
        idle(3, 0);
        check("t1_valid_held", cmd_valid, 1'b1);
        check("t1_code_held", cmd_code, 4'h5);
        step(0, 8'h00, 0, 8'h00, 1);
        check("t1_valid_drop", cmd_valid, 1'b0);
        idle(2, 1);

        // 2: both sources together, twice, ready high
        hs_cycle.delete();
        hs_code.delete();
        cyc = 0;
        step(1, 8'h01, 1, 8'h02, 1);
        step(1, 8'h01, 1, 8'h02, 1);
        idle(16, 1);
        check("t2_count", hs_code.size(), 4);
        check("t2_code0", hs_code[0], 4'h1);
        check("t2_code1", hs_code[1], 4'h2);
        check("t2_code2", hs_code[2], 4'h2);
        check("t2_code3", hs_code[3], 4'h1);
        check("t2_first_cycle", hs_cycle[0], 4);
        for (int i = 1; i < 4; i++)
            check("t2_spacing", hs_cycle[i] - hs_cycle[i-1], HOLD + 1);

        // 3: no-action key is discarded, next key unaffected
        base = hs_code.size();
        step(1, 8'h10, 0, 8'h00, 1);
        idle(6, 1);
        check("t3_no_cmd", hs_code.size(), base);
        step(0, 8'h00, 1, 8'h07, 1);
        idle(6, 1);
        check("t3_next_count", hs_code.size(), base + 1);
        check("t3_next_code", hs_code[base], 4'h7);

        // 4: back-pressure fills the queue and drops one byte
        for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 8'h00, 0);
        idle(3, 0);
        check("t4_full", fifo_full, 1'b1);
        check("t4_drops", drop_count, 8'd1);
        check("t4_offer_code", cmd_code, 4'h1);

        // 5: double drops and saturation
        step(1, 8'h0E, 1, 8'h0F, 0);
        check("t5_drop2", drop_count, 8'd3);
        for (int i = 0; i < 125; i++) step(1, 8'h0E, 1, 8'h0F, 0);
        step(1, 8'h0E, 0, 8'h00, 0);
        check("t5_fe", drop_count, 8'hFE);
        step(1, 8'h0E, 1, 8'h0F, 0);
        check("t5_sat", drop_count, 8'hFF);
        step(1, 8'h0E, 1, 8'h0F, 0);
        check("t5_sat_hold", drop_count, 8'hFF);

        // Release ready: queued codes drain in order
        base = hs_code.size();
        idle(20, 1);
        check("t4_drain_count", hs_code.size(), base + 5);
        for (int i = 0; i < 5; i++) check("t4_drain_code", hs_code[base + i], 4'(i + 1));

        // 6: asynchronous reset while offering with keys queued
        for (int i = 0; i < 4; i++) step(1, 8'h09 + 8'(i), 0, 8'h00, 0);
        idle(2, 0);
        check("t6_offering", cmd_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", cmd_valid, 1'b0);
        check("t6_rst_key", conv_key, IDLE);
        check("t6_rst_full", fifo_full, 1'b0);
        check("t6_rst_drops", drop_count, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = hs_code.size();
        idle(10, 1);
        check("t6_no_cmd", hs_code.size(), base);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 9) < 3,
                 8'($urandom), $urandom_range(0, 1) == 1);
        end
        idle(20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
